// File: rtl/pulse_train_generator.sv
// pulse_train_generator: multi-channel pulse/PWM generator for the thruster
// firing path. One shared period counter drives N_CH channels, each with its
// own width and delay. Configuration is double-buffered (shadow -> active at
// period boundaries) and an optional burst length stops generation after a
// fixed number of periods and pulses done.
//
// Optional feature macro: PULSE_TRAIN_GRACEFUL_STOP_EN
//   defined   : dropping run finishes the current period (STOPPING state),
//               then returns to IDLE with a done pulse.
//   undefined : dropping run aborts immediately; STOPPING does not exist.
//
// Handshake: load is a one-cycle strobe with no back-pressure; it is always
// accepted into the shadow set. run is a level; generation starts when run
// is high and the arm flag is set (arm is set by reset or by run low in IDLE).
module pulse_train_generator #(
  parameter int W    = 16,
  parameter int N_CH = 2,
  parameter int BW   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              load,
  input  logic [W-1:0]      period,
  input  logic [N_CH*W-1:0] width,
  input  logic [N_CH*W-1:0] delay,
  input  logic [BW-1:0]     burst_len,
  output logic [N_CH-1:0]   pulse_out,
  output logic              busy,
  output logic              done,
  output logic [1:0]        fsm_state
);

`ifdef PULSE_TRAIN_GRACEFUL_STOP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOPPING = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

  state_t state, state_next;

  logic [W-1:0]      sh_period, act_period, act_period_next;
  logic [N_CH*W-1:0] sh_width, act_width, act_width_next;
  logic [N_CH*W-1:0] sh_delay, act_delay, act_delay_next;
  logic [BW-1:0]     sh_burst, act_burst, act_burst_next;
  logic              pending, pending_next;
  logic              arm, arm_next;
  logic [W-1:0]      cnt, cnt_next;
  logic [BW-1:0]     burst_cnt, burst_cnt_next;
  logic [N_CH-1:0]   pulse_next;
  logic              finish, abort, enter_run;

  logic [W-1:0] p_eff;
  logic         wrap;
  logic         complete;

  // Effective period is clamped to 2; wrap is the last counter value of it.
  assign p_eff    = (act_period < W'(2)) ? W'(2) : act_period;
  assign wrap     = (state != IDLE) && (cnt == p_eff - W'(1));
  assign complete = wrap && (act_burst != '0) && ((burst_cnt + BW'(1)) == act_burst);
  assign fsm_state = state;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; completion outranks abort.
  always_comb begin
    state_next = state;
    finish     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (run && arm) state_next = RUN;
      end
      RUN: begin
        if (complete) begin
          state_next = IDLE;
          finish     = 1'b1;
        end else if (!run) begin
`ifdef PULSE_TRAIN_GRACEFUL_STOP_EN
          // run dropping on the wrap cycle means the current period is over.
          if (wrap) begin
            state_next = IDLE;
            finish     = 1'b1;
          end else begin
            state_next = STOPPING;
          end
`else
          state_next = IDLE;
          abort      = 1'b1;
`endif
        end
      end
`ifdef PULSE_TRAIN_GRACEFUL_STOP_EN
      STOPPING: begin
        // run re-asserting here does not cancel the stop.
        if (wrap) begin
          state_next = IDLE;
          finish     = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Next values for counter, burst count, config buffers and outputs.
  always_comb begin
    enter_run = (state == IDLE) && (state_next == RUN);

    if (state_next == IDLE || enter_run || wrap) cnt_next = '0;
    else                                         cnt_next = cnt + W'(1);

    if (state_next == IDLE || enter_run) burst_cnt_next = '0;
    else if (wrap)                       burst_cnt_next = burst_cnt + BW'(1);
    else                                 burst_cnt_next = burst_cnt;

    act_period_next = act_period;
    act_width_next  = act_width;
    act_delay_next  = act_delay;
    act_burst_next  = act_burst;
    pending_next    = pending;
    if (wrap && load) begin
      // A load coinciding with the wrap goes straight to the active set.
      act_period_next = period;
      act_width_next  = width;
      act_delay_next  = delay;
      act_burst_next  = burst_len;
      pending_next    = 1'b0;
    end else begin
      if (pending && (wrap || state == IDLE || abort)) begin
        act_period_next = sh_period;
        act_width_next  = sh_width;
        act_delay_next  = sh_delay;
        act_burst_next  = sh_burst;
        pending_next    = 1'b0;
      end
      if (load) pending_next = 1'b1;
    end

    if (enter_run)                          arm_next = 1'b0;
    else if (state == IDLE && !run)         arm_next = 1'b1;
    else                                    arm_next = arm;

    // Outputs are registered, so evaluate the window against the next
    // counter value; a pulse never wraps because the counter stops at p_eff-1.
    pulse_next = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (state_next != IDLE &&
          cnt_next >= act_delay_next[k*W +: W] &&
          {1'b0, cnt_next} < ({1'b0, act_delay_next[k*W +: W]} + {1'b0, act_width_next[k*W +: W]}))
        pulse_next[k] = 1'b1;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_period  <= '0;
      sh_width   <= '0;
      sh_delay   <= '0;
      sh_burst   <= '0;
      act_period <= '0;
      act_width  <= '0;
      act_delay  <= '0;
      act_burst  <= '0;
      pending    <= 1'b0;
      arm        <= 1'b1;
      cnt        <= '0;
      burst_cnt  <= '0;
      pulse_out  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (load) begin
        sh_period <= period;
        sh_width  <= width;
        sh_delay  <= delay;
        sh_burst  <= burst_len;
      end
      act_period <= act_period_next;
      act_width  <= act_width_next;
      act_delay  <= act_delay_next;
      act_burst  <= act_burst_next;
      pending    <= pending_next;
      arm        <= arm_next;
      cnt        <= cnt_next;
      burst_cnt  <= burst_cnt_next;
      pulse_out  <= pulse_next;
      busy       <= (state_next != IDLE);
      done       <= finish;
    end
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Bench for pulse_train_generator (N_CH=2, W=16). Expected {done,busy,pulse}
// words are pushed when a cycle is driven and popped after the next edge.
module tb_pulse_train_generator;
  localparam int W    = 16;
  localparam int N_CH = 2;
  localparam int BW   = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              run;
  logic              load;
  logic [W-1:0]      period;
  logic [N_CH*W-1:0] width;
  logic [N_CH*W-1:0] delay;
  logic [BW-1:0]     burst_len;
  logic [N_CH-1:0]   pulse_out;
  logic              busy;
  logic              done;
  logic [1:0]        fsm_state;

  pulse_train_generator #(.W(W), .N_CH(N_CH), .BW(BW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .load(load), .period(period),
    .width(width), .delay(delay), .burst_len(burst_len),
    .pulse_out(pulse_out), .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  // Clock.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];

  // Expected active configuration and counter position.
  int m_c;
  int m_p;
  int m_w[2];
  int m_d[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int peff();
    return (m_p < 2) ? 2 : m_p;
  endfunction

  function automatic logic [1:0] exp_pulse(input int c);
    logic [1:0] r;
    r = 2'b00;
    for (int k = 0; k < 2; k++)
      if (c >= m_d[k] && c < m_d[k] + m_w[k]) r[k] = 1'b1;
    return r;
  endfunction

  task automatic step_chk(input string tag);
    logic [3:0] e;
    @(posedge clk);
    #1;
    // 4'hF (done and busy together) can never be produced, so an empty
    // queue shows up as a mismatch.
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hF;
    check(tag, {28'd0, done, busy, pulse_out}, {28'd0, e});
  endtask

  task automatic idle_step(input string tag);
    exp_q.push_back(4'b0000);
    step_chk(tag);
  endtask

  task automatic done_step(input string tag);
    exp_q.push_back(4'b1000);
    step_chk(tag);
  endtask

  task automatic run_step(input string tag);
    exp_q.push_back({2'b01, exp_pulse(m_c)});
    step_chk(tag);
    m_c = (m_c + 1) % peff();
  endtask

  task automatic run_steps(input string tag, input int n);
    for (int i = 0; i < n; i++) run_step(tag);
  endtask

  // Load a configuration while IDLE; it becomes active one cycle later.
  task automatic drive_cfg(input int p, input int w0, input int d0,
                           input int w1, input int d1, input int b);
    period    = W'(p);
    width     = {W'(w1), W'(w0)};
    delay     = {W'(d1), W'(d0)};
    burst_len = BW'(b);
    load      = 1'b1;
    idle_step("cfg_load");
    load      = 1'b0;
    idle_step("cfg_copy");
    m_p = p; m_w[0] = w0; m_d[0] = d0; m_w[1] = w1; m_d[1] = d1;
  endtask

  task automatic start_run();
    run = 1'b1;
    m_c = 0;
  endtask

  task automatic stop_run(input string tag);
    run = 1'b0;
`ifdef PULSE_TRAIN_GRACEFUL_STOP_EN
    while (m_c != 0) run_step(tag);
    done_step(tag);
`else
    idle_step(tag);
`endif
    idle_step(tag);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; load = 1'b0;
    period = '0; width = '0; delay = '0; burst_len = '0;
    m_c = 0; m_p = 0; m_w = '{0, 0}; m_d = '{0, 0};

    // Reset state.
    idle_step("reset");
    idle_step("reset");
    check("reset_state", {30'd0, fsm_state}, 32'd0);
    rst_n = 1'b1;
    idle_step("post_reset");

    // Basic: two channels, continuous; run is dropped with counter at 4.
    drive_cfg(10, 3, 0, 2, 5, 0);
    start_run();
    run_steps("basic", 35);
    stop_run("abort");

    // Reset in the middle of a period.
    start_run();
    run_steps("pre_reset", 4);
    rst_n = 1'b0;
    run   = 1'b0;
    idle_step("mid_reset");
    check("mid_reset_state", {30'd0, fsm_state}, 32'd0);
    rst_n = 1'b1;
    idle_step("post_reset2");

    // Burst of three periods, no restart while run stays high.
    drive_cfg(4, 1, 0, 0, 0, 3);
    start_run();
    run_steps("burst", 12);
    done_step("burst_done");
    for (int i = 0; i < 4; i++) idle_step("no_restart");
    run = 1'b0;
    idle_step("rearm");
    start_run();
    run_steps("restart", 2);
    stop_run("burst_stop");

    // Truncation at the period end, zero width channel.
    drive_cfg(8, 0, 0, 5, 6, 0);
    start_run();
    run_steps("trunc", 16);
    stop_run("trunc_stop");

    // Period 1 clamps to 2.
    drive_cfg(1, 1, 0, 5, 1, 0);
    start_run();
    run_steps("p_clamp", 6);
    stop_run("p_clamp_stop");

    // Double buffering: mid-period load, load on the wrap, overwritten load.
    drive_cfg(10, 3, 0, 2, 5, 0);
    start_run();
    run_steps("dbuf_a", 4);
    width = {W'(2), W'(7)};
    load  = 1'b1;
    run_step("dbuf_mid");
    load  = 1'b0;
    while (m_c != 0) run_step("dbuf_old");
    m_w[0] = 7;
    run_steps("dbuf_new", 10);
    width = {W'(2), W'(5)};
    load  = 1'b1;
    m_w[0] = 5;
    run_step("dbuf_wrap");
    load  = 1'b0;
    run_steps("dbuf_wrap_p", 9);
    run_steps("dbuf_b", 3);
    width = {W'(2), W'(4)};
    load  = 1'b1;
    run_step("dbuf_ld1");
    width = {W'(2), W'(6)};
    run_step("dbuf_ld2");
    load  = 1'b0;
    while (m_c != 0) run_step("dbuf_old2");
    m_w[0] = 6;
    run_steps("dbuf_last", 10);
    run_steps("dbuf_pre_stop", 5);
    stop_run("dbuf_stop");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pulse_train_generator.md
Name: pulse_train_generator

Overview:
- Multi-channel, parametrised pulse/PWM generator for the thruster firing path.
- One shared period counter drives N_CH channels. Each channel has its own pulse width and phase delay.
- Adds double-buffered configuration (glitch-free updates at period boundaries) and a burst mode that fires a fixed number of periods, then stops and flags done.

Parameters:
- W, 16, bit width of the period, width and delay values
- N_CH, 2, number of output channels (1..8)
- BW, 16, bit width of the burst length

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- run  in  1  enable; a rising edge (or high level after reset/abort) starts generation
- load  in  1  one-cycle strobe; captures period/width/delay/burst_len into the shadow set
- period  in  W  period in clk cycles
- width  in  N_CH*W  per-channel high time; channel k occupies bits [k*W +: W]
- delay  in  N_CH*W  per-channel offset from period start, same packing
- burst_len  in  BW  number of periods per burst; 0 = continuous
- pulse_out  out  N_CH  registered channel outputs
- busy  out  1  high while in RUN (or STOPPING)
- done  out  1  one-cycle pulse on burst completion

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, counter=0, burst count=0, pending=0, pulse_out=0, busy=0, done=0. Active and shadow config are cleared to 0.
- Config path:
  - load captures the inputs into the shadow set.
  - In IDLE, shadow→active copy happens on the cycle after load.
  - In RUN, pending=1; the copy happens on the period wrap cycle. Load on the same cycle as a wrap is applied at that wrap.
  - A second load before the wrap overwrites the shadow; only the last one is applied.
- Period rule: P_eff = max(active period, 2). The counter runs 0..P_eff-1, then wraps to 0.
- Channel k is high when delay_k <= counter < delay_k+width_k:
  - The sum is computed in W+1 bits.
  - No wrap-around: a pulse that extends past P_eff-1 is truncated at the period end.
  - width_k=0 means the channel is never high.
  - delay_k=0 with width_k>=P_eff means the channel is constant high.
- States: IDLE, RUN, STOPPING (STOPPING exists only with the optional feature).
- IDLE→RUN: run=1 and the arm flag is set.
  - The arm flag is set by reset, or by run being sampled low in IDLE.
  - On entry: counter=0 and arm is cleared.
  - Outputs are registered. The first cycle with busy=1 shows counter=0, and pulse_out[k] already reflects counter=0 (e.g. delay 0, width>0 → high).
  - Latency from the run sample to the first output is 1 cycle.
- RUN, burst count:
  - burst count increments on each wrap.
  - With burst_len=B>0, the wrap that completes period B does three things: go to IDLE, pulse done for exactly 1 cycle, and set pulse_out=0 on that same cycle.
  - Restarting requires run low for at least 1 cycle (re-arm).
  - With B=0, generation runs until run drops.
- Abort: run=0 in RUN → next cycle IDLE, pulse_out=0, busy=0, counter=0, done not asserted. A pending load is applied immediately.
- Precedence: reset > completion > abort > load. When a burst completes and run falls on the same cycle, done still pulses.
- busy is registered and equals (state != IDLE).

Optional Feature:
- Macro: PULSE_TRAIN_GRACEFUL_STOP_EN.
- Defined: run=0 in RUN moves to STOPPING. The current period finishes normally, then the block goes to IDLE at the wrap with done=1 for 1 cycle and pulse_out=0.
  - run re-asserting during STOPPING does not cancel the stop.
  - Burst completion inside STOPPING behaves identically (single done pulse).
- Undefined: immediate abort as described under Behaviour; the STOPPING state does not exist.

Test Plan:
- All tests use N_CH=2, W=16.
- Basic: load P=10, w0=3, d0=0, w1=2, d1=5, B=0; run=1 → ch0 high for counter 0-2 and ch1 high for 5-6, every 10 cycles; busy=1; done never asserted.
- Burst: P=4, w0=1, B=3, run held high → exactly 3 ch0 pulses, done high for 1 cycle at the third wrap, then IDLE. No restart until run drops for 1 cycle and rises again.
- Truncation/clamp:
  - P=8, d1=6, w1=5 → ch1 high for counter 6-7 only.
  - P=1 → behaves as P_eff=2.
  - w0=0 → ch0 stays low.
- Double-buffer: mid-period (counter=3, P=10), load w0=7 → current period keeps w0=3 and the next period shows w0=7. A load on the wrap cycle applies at that wrap.
- Abort/reset:
  - run=0 at counter=4 → next cycle all outputs 0, busy=0, done=0.
  - rst_n=0 mid-period → all outputs 0 after the next clk edge.
  - With the macro defined, run=0 at counter=4 → pulses continue to counter 9, then done=1 and IDLE.
